// File: rtl/scale_scan_ctrl.sv
// scale_scan_ctrl: raster-scan sequencer for the image scaler.
// Walks the source image row by row, applies vertical decimation with a
// mul/div accumulator, drives next/rowend to the horizontal dot-decision stage
// and writes every pixel it keeps, packed, to destination memory.
// Optional build macro SCALE_SCAN_OUTREG_EN registers the destination write
// port (one extra cycle of write latency) and delays done to match.
module scale_scan_ctrl #(
    parameter int AW = 12,
    parameter int DW = 8,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] src_w,
    input  logic [CW-1:0] src_h,
    input  logic [CW-1:0] mul_V,
    input  logic [CW-1:0] div_V,
    output logic          src_rd,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic          next,
    output logic          rowend,
    input  logic          getdot,
    output logic          dst_wr,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_CHK,
        S_SCAN,
        S_DRAIN,
        S_ROW_NEXT,
        S_DONE
    } state_t;

    state_t        state, state_nx;

    // Frame configuration captured on an accepted start.
    logic [CW-1:0] w_r, h_r, mul_r, div_r;
    // Vertical accumulator always stays below div_r, so CW bits suffice.
    logic [CW-1:0] vacc;
    logic [CW-1:0] row, col;
    logic [AW-1:0] dst_ptr;
    logic          kept_q;      // current row was kept, so rowend follows DRAIN
    logic          next_q;      // read issued last cycle -> data valid now

    logic          rd_c, rowend_c, busy_c, done_c;
    logic [CW:0]   vsum, row_inc;
    logic          keep, last_col, last_row, wr_c;
    logic [AW-1:0] addr_c;

    // One extra bit so vacc+mul_V can never wrap before the compare.
    assign vsum     = {1'b0, vacc} + {1'b0, mul_r};
    assign keep     = (vsum >= {1'b0, div_r});
    assign last_col = (col == w_r - CW'(1));
    assign row_inc  = {1'b0, row} + (CW+1)'(1);
    assign last_row = (row_inc == {1'b0, h_r});
    assign addr_c   = AW'(row) * AW'(w_r) + AW'(col);
    assign wr_c     = next_q & getdot;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and the per-state strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        state_nx = state;
        rd_c     = 1'b0;
        rowend_c = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    rowend_c = 1'b1;    // horizontal stage starts the frame cleared
                    state_nx = S_ROW_CHK;
                end
            end
            S_ROW_CHK: begin
                busy_c = 1'b1;
                if (keep) begin
                    state_nx = S_SCAN;
                end else begin
                    rowend_c = 1'b1;
                    state_nx = S_ROW_NEXT;
                end
            end
            S_SCAN: begin
                busy_c = 1'b1;
                rd_c   = 1'b1;
                if (last_col) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy_c   = 1'b1;        // last next/getdot lands in this cycle
                state_nx = S_ROW_NEXT;
            end
            S_ROW_NEXT: begin
                busy_c   = 1'b1;
                rowend_c = kept_q;      // one cycle after the last next of a kept row
                state_nx = last_row ? S_DONE : S_ROW_CHK;
            end
            S_DONE: begin
                done_c   = 1'b1;        // start is ignored here as well
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Configuration, accumulator, scan counters, read pipeline and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_r     <= '0;
            h_r     <= '0;
            mul_r   <= '0;
            div_r   <= '0;
            vacc    <= '0;
            row     <= '0;
            col     <= '0;
            dst_ptr <= '0;
            kept_q  <= 1'b0;
            next_q  <= 1'b0;
        end else begin
            next_q <= rd_c;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        w_r     <= src_w;
                        h_r     <= src_h;
                        mul_r   <= mul_V;
                        div_r   <= div_V;
                        vacc    <= '0;
                        row     <= '0;
                        dst_ptr <= '0;
                        kept_q  <= 1'b0;
                    end
                end
                S_ROW_CHK: begin
                    vacc   <= keep ? CW'(vsum - {1'b0, div_r}) : vsum[CW-1:0];
                    col    <= '0;
                    kept_q <= keep;
                end
                S_SCAN:     col <= col + CW'(1);
                S_ROW_NEXT: row <= row + CW'(1);
                default: ;
            endcase
            // Writes only happen while next_q is high, never in IDLE, so no clash with the clear.
            if (wr_c) dst_ptr <= dst_ptr + AW'(1);
        end
    end

    assign src_rd   = rd_c;
    assign src_addr = rd_c ? addr_c : '0;
    assign next     = next_q;
    assign rowend   = rowend_c;
    assign busy     = busy_c;

`ifdef SCALE_SCAN_OUTREG_EN
    logic          dst_wr_q, done_q;
    logic [AW-1:0] dst_addr_q;
    logic [DW-1:0] dst_data_q;

    // Registered write port; done slips one cycle so it follows the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_wr_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            dst_wr_q   <= wr_c;
            dst_addr_q <= wr_c ? dst_ptr : '0;
            dst_data_q <= wr_c ? src_data : '0;
            done_q     <= done_c;
        end
    end

    assign dst_wr   = dst_wr_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_data_q;
    assign done     = done_q;
`else
    assign dst_wr   = wr_c;
    assign dst_addr = wr_c ? dst_ptr : '0;
    assign dst_data = wr_c ? src_data : '0;
    assign done     = done_c;
`endif

endmodule

// File: tb/tb_scale_scan_ctrl.sv
// tb_scale_scan_ctrl: self-checking bench for scale_scan_ctrl.
// Provides a synchronous source memory and a behavioural horizontal stage,
// predicts each frame from floor-ratio arithmetic and compares the captured
// write stream, strobe counts and done timing.
module tb_scale_scan_ctrl;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int CW = 6;
`ifdef SCALE_SCAN_OUTREG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] src_w, src_h, mul_V, div_V;
    logic          src_rd;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data = '0;
    logic          next, rowend, getdot;
    logic          dst_wr;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;
    logic          busy, done;

    scale_scan_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_w(src_w), .src_h(src_h), .mul_V(mul_V), .div_V(div_V),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .next(next), .rowend(rowend), .getdot(getdot),
        .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mul_h = 1;
    int div_h = 1;
    int hcnt  = 0;
    logic [7:0] salt = '0;

    // Source pixel value for a given address.
    function automatic logic [DW-1:0] pix(input int a);
        return DW'(a) ^ salt;
    endfunction

    // Ratio keep rule: index i survives when floor((i+1)*m/d) steps past floor(i*m/d).
    function automatic bit ratio_keep(input int i, input int m, input int d);
        return ((i + 1) * m) / d > (i * m) / d;
    endfunction

    // Synchronous source memory.
    always @(posedge clk) if (src_rd) src_data <= pix(int'(src_addr));

    // Horizontal stage stand-in: counts pixels since rowend, keeps by ratio.
    always @(posedge clk or posedge rst) begin
        if (rst)         hcnt <= 0;
        else if (rowend) hcnt <= 0;
        else if (next)   hcnt <= hcnt + 1;
    end
    assign getdot = next && ratio_keep(hcnt, mul_h, div_h);

    // Output monitor, sampled on the falling edge.
    int   n_rd = 0, n_next = 0, n_rowend = 0, n_lat = 0, n_coinc = 0;
    logic prev_rd = 1'b0;
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (src_rd) n_rd++;
            if (next) n_next++;
            if (rowend) n_rowend++;
            if (next !== prev_rd) n_lat++;
            if (next && rowend) n_coinc++;
            if (dst_wr) begin
                wq_addr.push_back(dst_addr);
                wq_data.push_back(dst_data);
            end
            prev_rd = src_rd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, {26'd0, src_rd, next, rowend, dst_wr, busy, done}, 32'd0);
        check({tag, "_src_addr"}, 32'(src_addr), 32'd0);
        check({tag, "_dst_addr"}, 32'(dst_addr), 32'd0);
        check({tag, "_dst_data"}, 32'(dst_data), 32'd0);
    endtask

    // Runs one frame and compares it with the ratio-arithmetic prediction.
    task automatic run_frame(input string tag, input int w, input int h, input int mv,
                             input int dv, input int mh, input int dh, input bit glitch);
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        int r_cyc = 0, kept_rows = 0, ptr = 0, exp_cyc, cyc = 0;
        int b_rd, b_next, b_rowend, b_lat, b_coinc, b_w, nw;
        bit seen = 0;
        for (int r = 0; r < h; r++) begin
            if (ratio_keep(r, mv, dv)) begin
                kept_rows++;
                r_cyc += 2 + w + 1;
                for (int c = 0; c < w; c++)
                    if (ratio_keep(c, mh, dh)) begin
                        ea.push_back(AW'(ptr));
                        ed.push_back(pix(r * w + c));
                        ptr++;
                    end
            end else begin
                r_cyc += 2;
            end
        end
        exp_cyc = r_cyc + 1 + LAG;
        b_rd = n_rd; b_next = n_next; b_rowend = n_rowend;
        b_lat = n_lat; b_coinc = n_coinc; b_w = wq_addr.size();
        mul_h = mh; div_h = dh;
        @(posedge clk); #1;
        src_w = CW'(w); src_h = CW'(h); mul_V = CW'(mv); div_V = CW'(dv);
        start = 1'b1;
        while (!seen && cyc < exp_cyc + 10) begin
            @(posedge clk); cyc++; #1;
            start = glitch && (cyc == 3 || cyc == exp_cyc - LAG);
            if (glitch && cyc == 2) begin
                src_w = CW'($urandom_range(1, 63)); src_h = CW'($urandom_range(1, 63));
                mul_V = CW'($urandom_range(0, 5));  div_V = CW'($urandom_range(5, 9));
            end
            @(negedge clk);
            if (done) seen = 1;
            else if (cyc == 1) check({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); @(posedge clk); @(negedge clk);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_rd_count"}, 32'(n_rd - b_rd), 32'(kept_rows * w));
        check({tag, "_next_count"}, 32'(n_next - b_next), 32'(kept_rows * w));
        check({tag, "_rowend_count"}, 32'(n_rowend - b_rowend), 32'(h + 1));
        check({tag, "_next_latency"}, 32'(n_lat - b_lat), 32'd0);
        check({tag, "_rowend_vs_next"}, 32'(n_coinc - b_coinc), 32'd0);
        nw = wq_addr.size() - b_w;
        check({tag, "_wr_count"}, 32'(nw), 32'(ea.size()));
        for (int i = 0; i < nw && i < ea.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), 32'(wq_addr[b_w + i]), 32'(ea[i]));
            check($sformatf("%s_wr%0d_data", tag, i), 32'(wq_data[b_w + i]), 32'(ed[i]));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        src_w = '0; src_h = '0; mul_V = '0; div_V = '0;
        #1 check_quiet("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk) check_quiet("reset1");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) check_quiet("idle");

        // 4x4, rows 1,3 and cols 1,3 kept -> src 5,7,13,15 to dst 0..3.
        salt = 8'h00;
        run_frame("half", 4, 4, 1, 2, 1, 2, 1'b0);
        // 3x2 all kept, data equals source address.
        run_frame("full", 3, 2, 2, 2, 5, 5, 1'b0);
        // No row kept: only rowend pulses.
        run_frame("none", 4, 4, 0, 3, 1, 1, 1'b0);
        // start during the frame and in DONE must change nothing.
        salt = 8'h5a;
        run_frame("glitch", 4, 4, 1, 2, 1, 2, 1'b1);

        // Reset in the middle of row 1's scan.
        mul_h = 1; div_h = 1;
        src_w = 6'd4; src_h = 6'd4; mul_V = 6'd1; div_V = 6'd1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) check("abort_pre_rd", 32'(src_rd), 32'd1);
        #2 rst = 1'b1;
        #1 check_quiet("abort_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) check_quiet("abort_hold");
        @(posedge clk); #1 rst = 1'b0;
        run_frame("after_abort", 4, 4, 1, 2, 1, 2, 1'b0);

        // Single pixel frame.
        run_frame("one", 1, 1, 1, 1, 1, 1, 1'b0);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            int w, h, dv, mv, dh, mh;
            w  = $urandom_range(1, 10); h  = $urandom_range(1, 10);
            dv = $urandom_range(1, 7);  mv = $urandom_range(0, dv);
            dh = $urandom_range(1, 7);  mh = $urandom_range(0, dh);
            salt = 8'($urandom);
            run_frame($sformatf("rand%0d", k), w, h, mv, dv, mh, dh, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scale_scan_ctrl.md
Name: scale_scan_ctrl

Overview:
- Raster-scan sequencer for the image-scaling datapath; sits directly upstream of the horizontal dot-decision stage.
- Walks the source image row by row and reads pixels from source memory.
- Drives the horizontal stage's next/rowend strobes and takes back its getdot decision.
- Applies vertical decimation with its own mul/div accumulator and writes every kept pixel, packed, to destination memory.

Parameters:
- AW, 12, source/destination address width.
- DW, 8, pixel data width.
- CW, 6, coordinate and ratio width; image dimensions 1..2^CW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- src_w  in  CW  source width in pixels; sampled on accepted start.
- src_h  in  CW  source height in rows; sampled on accepted start.
- mul_V  in  CW  vertical ratio numerator; sampled on start.
- div_V  in  CW  vertical ratio denominator; sampled on start.
- src_rd  out  1  source memory read enable.
- src_addr  out  AW  source read address, row*src_w+col.
- src_data  in  DW  source read data; synchronous memory, valid 1 cycle after src_rd.
- next  out  1  pixel strobe to the horizontal stage, aligned with valid src_data.
- rowend  out  1  one-cycle pulse clearing the horizontal accumulator.
- getdot  in  1  combinational keep decision returned by the horizontal stage, same cycle as next.
- dst_wr  out  1  destination write enable.
- dst_addr  out  AW  destination write address.
- dst_data  out  DW  destination write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Clock/reset: reset rst, asynchronous, active-high; clock clk.
- Reset values: all outputs 0; FSM in IDLE; vacc, row, col and dst pointer at 0.
- Preconditions: 0 < div_V and mul_V <= div_V (same for the horizontal ratio). Violations are undefined; no checking is done.
- Latency: 1 cycle from src_rd to next.
- IDLE:
  - start=1 latches the configuration, clears vacc/row/dst pointer, sets busy, and moves to ROW_CHK.
- ROW_CHK (1 cycle):
  - keep = (vacc+mul_V >= div_V), computed at CW+1 bits with no overflow.
  - vacc <= keep ? vacc+mul_V-div_V : vacc+mul_V.
  - keep=1: go to SCAN with col=0.
  - keep=0: pulse rowend and go to ROW_NEXT.
- SCAN:
  - src_rd=1 and src_addr=row*src_w+col every cycle for col=0..src_w-1.
  - A pipeline bit delays src_rd by 1 cycle to produce next.
  - When next&getdot: dst_wr=1, dst_data=src_data, dst_addr=dst pointer, then pointer++. Write is combinational from that cycle's inputs.
  - After the last read issues, go to DRAIN.
- DRAIN (1 cycle):
  - Last next/getdot is handled.
  - rowend is pulsed in the cycle after the last next, never coincident with next.
  - Go to ROW_NEXT.
- ROW_NEXT:
  - row++.
  - row==src_h goes to DONE; otherwise go to ROW_CHK.
- DONE:
  - done=1 and busy=0 for 1 cycle, then IDLE.
  - The dst pointer holds the output pixel count until the next start.
- Boundary cases:
  - src_w=1: single read, then DRAIN.
  - mul_V=div_V: every row kept.
  - mul_V=0: no row kept; no src_rd, no dst_wr, but rowend still pulses once per row.
- Write address: the dst pointer wraps modulo 2^AW; no saturation.
- start while busy: ignored, including in the DONE cycle.
- Reset mid-frame: immediate abort to the reset state. A read outstanding at that moment produces no next.
- rowend is also pulsed once on accepted start, so the horizontal stage begins the frame cleared.

Optional Feature:
- Macro: SCALE_SCAN_OUTREG_EN.
- Defined: dst_wr, dst_addr and dst_data are registered, adding 1 cycle of write latency. done is delayed by 1 cycle so it follows the last write.
- Undefined: write outputs are combinational as described above.

Test Plan:
- 4x4 frame, mul_V=1, div_V=2, horizontal stage instantiated with mul_H=1, div_H=2 -> rows 1,3 kept; writes src addrs 5,7,13,15 to dst 0..3; done 1 cycle after the last ROW_NEXT.
- 3x2 frame, mul_V=div_V=2, horizontal mul_H=div_H=5 -> 6 writes, dst_data equal to src addr 0..5 in order; rowend exactly 3 times (start plus 2 rows).
- mul_V=0, 4x4 -> zero src_rd and zero dst_wr; 5 rowend pulses; busy 0 after done.
- start asserted again mid-frame and during DONE -> no effect; the output sequence is identical to a clean run.
- rst pulsed during SCAN of row 1, then a fresh start -> all outputs 0 during reset; new frame writes start at dst_addr 0.
- src_w=1, src_h=1, ratios 1/1 -> 1 read, next 1 cycle later, 1 write to dst 0, rowend the cycle after next.
